// File: rtl/pulse_width_decoder.sv
// pulse_width_decoder
// Qualifies and measures high pulses on an asynchronous pulse line, rejects
// pulses outside [min_width, max_width] and counts the accepted ones over a
// programmable gate window.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   pulse_in      asynchronous pulse line, active high
//   min_width     minimum accepted width in clocks
//   max_width     maximum accepted width in clocks (0 = no upper limit)
//   gate_len      gate window length in clocks (0 = gating disabled)
//   clr           synchronous soft clear, same effect as reset
//   width_out     width of the last accepted pulse
//   width_valid   one-cycle strobe, width_out updated
//   reject_short  one-cycle strobe, pulse ended below min_width
//   reject_long   one-cycle strobe, pulse exceeded max_width
//   count_out     accepted-pulse count of the last completed gate
//   count_valid   one-cycle strobe at gate end
//   busy          high while measuring or waiting for the line to go low
module pulse_width_decoder #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] min_width,
  input  logic [CNT_W-1:0] max_width,
  input  logic [CNT_W-1:0] gate_len,
  input  logic             clr,
  output logic [CNT_W-1:0] width_out,
  output logic             width_valid,
  output logic             reject_short,
  output logic             reject_long,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic [CNT_W-1:0]       wcnt;
  logic [CNT_W-1:0]       wcnt_nx;
  logic [CNT_W-1:0]       gate_cnt;
  logic [CNT_W-1:0]       acc;
  logic [CNT_W-1:0]       acc_nx_c;
  logic                   accept_c;
  logic                   short_c;
  logic                   long_c;
  logic                   soft_rst;
  logic                   gate_end_c;

  assign soft_rst = !rst_n || clr;
  assign s        = sync[SYNC_STAGES-1];

  // Input synchroniser; presets to 1 so a line held high through reset
  // never looks like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      sync <= '1;
      s_d  <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pulse_in};
      s_d  <= s;
    end
  end

  // State and width counter registers
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state <= WAIT_LOW;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Next-state, width counting and pulse classification
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    accept_c = 1'b0;
    short_c  = 1'b0;
    long_c   = 1'b0;
    case (state)
      IDLE: begin
        if (s && !s_d) begin
          state_nx = MEASURE;
          wcnt_nx  = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (s) begin
          if ((max_width != '0) && (wcnt == max_width)) begin
            long_c   = 1'b1;
            state_nx = WAIT_LOW;
          end else if (wcnt != CNT_MAX) begin
            wcnt_nx = wcnt + CNT_W'(1);
          end
        end else begin
          if (wcnt < min_width) begin
            short_c = 1'b1;
          end else begin
            accept_c = 1'b1;
          end
          state_nx = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!s) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = WAIT_LOW;
      end
    endcase
  end

  // Accumulator value including an accept in this cycle (saturating)
  always_comb begin
    acc_nx_c = acc;
    if (accept_c && (acc != CNT_MAX)) begin
      acc_nx_c = acc + CNT_W'(1);
    end
  end

  assign gate_end_c = (gate_len != '0) && (gate_cnt == (gate_len - CNT_W'(1)));

  // Gate window: closing cycle hands the running count (with any same-cycle
  // accept) to count_out and restarts from zero.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      gate_cnt    <= '0;
      acc         <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (gate_len == '0) begin
        gate_cnt <= '0;
        acc      <= acc_nx_c;
      end else if (gate_end_c) begin
        gate_cnt    <= '0;
        acc         <= '0;
        count_out   <= acc_nx_c;
        count_valid <= 1'b1;
      end else begin
        gate_cnt <= gate_cnt + CNT_W'(1);
        acc      <= acc_nx_c;
      end
    end
  end

  // Registered pulse outputs
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      width_out    <= '0;
      width_valid  <= 1'b0;
      reject_short <= 1'b0;
      reject_long  <= 1'b0;
      busy         <= 1'b1;
    end else begin
      width_valid  <= accept_c;
      reject_short <= short_c;
      reject_long  <= long_c;
      busy         <= (state_nx != IDLE);
      if (accept_c) begin
        width_out <= wcnt;
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed self-checking bench for pulse_width_decoder.
module tb_pulse_width_decoder;

  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             pulse_in;
  logic [CNT_W-1:0] min_width;
  logic [CNT_W-1:0] max_width;
  logic [CNT_W-1:0] gate_len;
  logic             clr;
  logic [CNT_W-1:0] width_out;
  logic             width_valid;
  logic             reject_short;
  logic             reject_long;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             busy;

  int checks;
  int failures;

  // Strobe statistics collected by run_seq; indices count edges from the
  // first edge of the sequence (index 0).
  int wv_cnt, wv_first, wv_last;
  int rs_cnt, rs_first;
  int rl_cnt, rl_first;
  int excl_bad;
  logic [CNT_W-1:0] w_last;

  pulse_width_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pulse_in     (pulse_in),
    .min_width    (min_width),
    .max_width    (max_width),
    .gate_len     (gate_len),
    .clr          (clr),
    .width_out    (width_out),
    .width_valid  (width_valid),
    .reject_short (reject_short),
    .reject_long  (reject_long),
    .count_out    (count_out),
    .count_valid  (count_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_exclusive();
    if (32'(width_valid) + 32'(reject_short) + 32'(reject_long) > 1) excl_bad++;
  endtask

  // Drive pat[i] before edge i, record strobes seen after each edge.
  task automatic run_seq(input logic [63:0] pat, input int len);
    wv_cnt = 0; wv_first = -1; wv_last = -1;
    rs_cnt = 0; rs_first = -1;
    rl_cnt = 0; rl_first = -1;
    w_last = '0;
    for (int i = 0; i < len; i++) begin
      pulse_in = pat[i];
      tick();
      note_exclusive();
      if (width_valid) begin
        wv_cnt++;
        if (wv_first < 0) wv_first = i;
        wv_last = i;
        w_last  = width_out;
      end
      if (reject_short) begin
        rs_cnt++;
        if (rs_first < 0) rs_first = i;
      end
      if (reject_long) begin
        rl_cnt++;
        if (rl_first < 0) rl_first = i;
      end
    end
    pulse_in = 1'b0;
  endtask

  // Single pulse of n high samples followed by a quiet tail.
  task automatic pulse(input int n);
    logic [63:0] pat;
    pat = (64'(1) << n) - 64'(1);
    run_seq(pat, n + 8);
  endtask

  task automatic test_reset();
    int strobes;
    int busy_low;
    rst_n = 1'b0; clr = 1'b0; pulse_in = 1'b1;
    min_width = '0; max_width = '0; gate_len = '0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (width_out !== '0 || count_out !== '0 || busy !== 1'b1 ||
        width_valid !== 1'b0 || reject_short !== 1'b0 ||
        reject_long !== 1'b0 || count_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: width_out=%0d count_out=%0d busy=%b strobes=%b%b%b%b, want 0 0 1 0000",
               width_out, count_out, busy, width_valid, reject_short, reject_long, count_valid);
    end
    rst_n = 1'b1;
    strobes = 0; busy_low = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (width_valid || reject_short || reject_long || count_valid) strobes++;
      if (busy !== 1'b1) busy_low++;
    end
    pulse_in = 1'b0;
    tick();
    if (width_valid || reject_short || reject_long) strobes++;
    tick();
    if (width_valid || reject_short || reject_long) strobes++;
    checks++;
    if (busy !== 1'b1 || busy_low != 0) begin
      failures++;
      $display("FAIL held_high_busy: busy=%b busy_low_cycles=%0d, want busy=1 and 0", busy, busy_low);
    end
    tick();
    if (width_valid || reject_short || reject_long) strobes++;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_fall: busy=%b, want 0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (width_valid || reject_short || reject_long) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL held_high_strobes: got %0d strobes, want 0", strobes);
    end
  endtask

  task automatic test_accept();
    min_width = 32'd3; max_width = 32'd100;
    pulse(10);
    // pulse_in first sampled low at index 10; strobe two edges later
    checks++;
    if (wv_cnt != 1 || wv_first != 12 || w_last !== 32'd10 || rs_cnt != 0 || rl_cnt != 0) begin
      failures++;
      $display("FAIL accept_10: wv_cnt=%0d at=%0d width=%0d rs=%0d rl=%0d, want 1 12 10 0 0",
               wv_cnt, wv_first, w_last, rs_cnt, rl_cnt);
    end
    checks++;
    if (dut.acc !== 32'd1) begin
      failures++;
      $display("FAIL acc_after_accept: acc=%0d, want 1", dut.acc);
    end
  endtask

  task automatic test_short();
    min_width = 32'd3; max_width = 32'd100;
    pulse(2);
    checks++;
    if (rs_cnt != 1 || rs_first != 4 || wv_cnt != 0 || width_out !== 32'd10) begin
      failures++;
      $display("FAIL reject_short_2: rs_cnt=%0d at=%0d wv_cnt=%0d width_out=%0d, want 1 4 0 10",
               rs_cnt, rs_first, wv_cnt, width_out);
    end
    checks++;
    if (dut.acc !== 32'd1) begin
      failures++;
      $display("FAIL acc_after_short: acc=%0d, want 1", dut.acc);
    end
    min_width = 32'd1;
    pulse(1);
    checks++;
    if (wv_cnt != 1 || wv_first != 3 || w_last !== 32'd1 || rs_cnt != 0) begin
      failures++;
      $display("FAIL accept_1_min1: wv_cnt=%0d at=%0d width=%0d rs=%0d, want 1 3 1 0",
               wv_cnt, wv_first, w_last, rs_cnt);
    end
  endtask

  task automatic test_long();
    min_width = 32'd3; max_width = 32'd8;
    pulse(8);
    checks++;
    if (wv_cnt != 1 || w_last !== 32'd8 || rl_cnt != 0) begin
      failures++;
      $display("FAIL max_exact_8: wv_cnt=%0d width=%0d rl=%0d, want 1 8 0", wv_cnt, w_last, rl_cnt);
    end
    pulse(9);
    checks++;
    if (rl_cnt != 1 || rl_first != 10 || wv_cnt != 0 || rs_cnt != 0 || width_out !== 32'd8) begin
      failures++;
      $display("FAIL max_plus1_9: rl_cnt=%0d at=%0d wv=%0d rs=%0d width_out=%0d, want 1 10 0 0 8",
               rl_cnt, rl_first, wv_cnt, rs_cnt, width_out);
    end
  endtask

  task automatic test_gate();
    int wv_in_win;
    logic [CNT_W-1:0] cnt_at_end;
    logic cv49, cv50, cv51, cv100;
    logic [CNT_W-1:0] cnt_at_100;
    min_width = 32'd3; max_width = 32'd100; gate_len = 32'd50;
    pulse_in = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wv_in_win = 0; cnt_at_end = '0; cnt_at_100 = '0;
    cv49 = 1'b0; cv50 = 1'b0; cv51 = 1'b0; cv100 = 1'b0;
    // Edge k after the clear edge; pulses high at k = 12+8j .. 15+8j
    for (int k = 1; k <= 100; k++) begin
      pulse_in = (k >= 12 && k < 52 && ((k - 12) % 8) < 4);
      tick();
      note_exclusive();
      if (k <= 50 && width_valid) wv_in_win++;
      if (k == 49) cv49 = count_valid;
      if (k == 50) begin cv50 = count_valid; cnt_at_end = count_out; end
      if (k == 51) cv51 = count_valid;
      if (k == 100) begin cv100 = count_valid; cnt_at_100 = count_out; end
    end
    gate_len = '0;
    checks++;
    if (wv_in_win != 5) begin
      failures++;
      $display("FAIL gate_accepts: got %0d accepts in window, want 5", wv_in_win);
    end
    checks++;
    if (cv49 !== 1'b0 || cv50 !== 1'b1 || cv51 !== 1'b0 || cnt_at_end !== 32'd5) begin
      failures++;
      $display("FAIL gate_close: cv49/50/51=%b%b%b count_out=%0d, want 010 5",
               cv49, cv50, cv51, cnt_at_end);
    end
    checks++;
    if (cv100 !== 1'b1 || cnt_at_100 !== 32'd0) begin
      failures++;
      $display("FAIL gate_second: count_valid=%b count_out=%0d, want 1 0", cv100, cnt_at_100);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pat;
    min_width = 32'd3; max_width = 32'd100;
    pat = 64'h7DF;  // 5 high, 1 low, 5 high
    run_seq(pat, 20);
    checks++;
    if (wv_cnt != 2 || wv_first != 7 || wv_last != 13 || w_last !== 32'd5) begin
      failures++;
      $display("FAIL back_to_back: wv_cnt=%0d first=%0d last=%0d width=%0d, want 2 7 13 5",
               wv_cnt, wv_first, wv_last, w_last);
    end
  endtask

  task automatic test_clear_mid_pulse();
    int strobes;
    min_width = 32'd3; max_width = 32'd100; gate_len = '0;
    pulse(4);
    pulse_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (dut.acc !== 32'd0 || busy !== 1'b1 || width_out !== 32'd0) begin
      failures++;
      $display("FAIL clear_state: acc=%0d busy=%b width_out=%0d, want 0 1 0", dut.acc, busy, width_out);
    end
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (width_valid || reject_short || reject_long) strobes++;
    end
    pulse_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (width_valid || reject_short || reject_long) strobes++;
    end
    checks++;
    if (strobes != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_aborted: strobes=%0d busy=%b, want 0 0", strobes, busy);
    end
    pulse(7);
    checks++;
    if (wv_cnt != 1 || wv_first != 9 || w_last !== 32'd7 || dut.acc !== 32'd1) begin
      failures++;
      $display("FAIL clear_next_pulse: wv_cnt=%0d at=%0d width=%0d acc=%0d, want 1 9 7 1",
               wv_cnt, wv_first, w_last, dut.acc);
    end
  endtask

  initial begin
    checks = 0; failures = 0; excl_bad = 0;
    test_reset();
    test_accept();
    test_short();
    test_long();
    test_gate();
    test_back_to_back();
    test_clear_mid_pulse();
    checks++;
    if (excl_bad != 0) begin
      failures++;
      $display("FAIL strobe_exclusive: %0d cycles with overlapping strobes, want 0", excl_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
